// File: rtl/tdc_read_pkg.sv
// Shared types for the multi-channel TDC read arbiter.
// Arbiter state encoding and channel index width helper.
package tdc_read_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdc_stop_sync.sv
// Two-flop synchroniser for one asynchronous TDC stop flag.
// Emits a one-cycle rise strobe on a synchronised 0->1 transition.
module tdc_stop_sync
  import tdc_read_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic stop,
  output logic rise
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= stop;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;

endmodule

// File: rtl/tdc_read_arbiter.sv
// Round-robin read arbiter for CH_NUM asynchronous TDC stop channels.
// Optional request timeout built when TDC_READ_TIMEOUT_EN is defined.
module tdc_read_arbiter
  import tdc_read_pkg::*;
#(
  parameter  int CH_NUM      = 4,
  parameter  int TIMEOUT_CYC = 255,
  localparam int CH_W        = ch_width(CH_NUM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH_NUM-1:0] tdc_stop,
  input  logic              read_ack,
  output logic              read_req,
  output logic [CH_W-1:0]   read_ch,
  output logic [CH_NUM-1:0] pending,
  output logic [CH_NUM-1:0] overrun,
  input  logic              overrun_clr,
  output logic              timeout
);

  localparam logic [CH_W:0] NCH = (CH_W+1)'(CH_NUM);
  localparam logic [CH_W:0] ONE = (CH_W+1)'(1);

  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   gnt;
  logic [CH_W-1:0]   ptr_nxt;
  logic [CH_W:0]     idx;
  logic [CH_W:0]     nxt;
  logic [CH_NUM-1:0] rise;
  logic [CH_NUM-1:0] gmask;
  logic              found;
  logic              grant;
  logic              expire;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_sync
    tdc_stop_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .stop  (tdc_stop[i]),
      .rise  (rise[i])
    );
  end

  // First pending channel at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = {1'b0, ptr} + (CH_W+1)'(k);
      if (idx >= NCH) idx = idx - NCH;
      if (!found && pending[idx[CH_W-1:0]]) begin
        found = 1'b1;
        gnt   = idx[CH_W-1:0];
      end
    end
  end

  assign grant   = (state == ST_IDLE) && found;
  assign nxt     = {1'b0, gnt} + ONE;
  assign ptr_nxt = (nxt == NCH) ? '0 : nxt[CH_W-1:0];

  always_comb begin
    gmask = '0;
    if (grant) gmask[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      read_req <= 1'b0;
      read_ch  <= '0;
      ptr      <= '0;
      pending  <= '0;
      overrun  <= '0;
    end else begin
      // A rise in the grant cycle re-arms instead of counting as lost.
      pending <= (pending & ~gmask) | rise;
      overrun <= (overrun_clr ? '0 : overrun)
               | (rise & pending & ~gmask);
      unique case (state)
        ST_IDLE: begin
          if (grant) begin
            state    <= ST_REQ;
            read_req <= 1'b1;
            read_ch  <= gnt;
            ptr      <= ptr_nxt;
          end
        end
        ST_REQ: begin
          if (read_ack || expire) begin
            state    <= ST_IDLE;
            read_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TDC_READ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt;

  assign expire = (state == ST_REQ) && !read_ack
                && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      if (grant) begin
        to_cnt <= '0;
      end else if (state == ST_REQ && !read_ack) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`else
  assign expire = 1'b0;

  // TIMEOUT_CYC only matters once the counter is built in.
  if (TIMEOUT_CYC >= 0) begin : g_no_timeout
    assign timeout = 1'b0;
  end
`endif

endmodule

// File: tb/tb_tdc_read_arbiter.sv
// Randomised and directed bench for tdc_read_arbiter against a queue/int model.
// Honours TDC_READ_TIMEOUT_EN for the timeout scenario.
module tb_tdc_read_arbiter;

  localparam int N    = 4;
  localparam int TCYC = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] tdc_stop = '0;
  logic         read_ack = 1'b0;
  logic         overrun_clr = 1'b0;
  logic         read_req;
  logic [1:0]   read_ch;
  logic [N-1:0] pending;
  logic [N-1:0] overrun;
  logic         timeout;

  tdc_read_arbiter #(
    .CH_NUM      (N),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tdc_stop    (tdc_stop),
    .read_ack    (read_ack),
    .read_req    (read_req),
    .read_ch     (read_ch),
    .pending     (pending),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: events, pending set, round-robin pointer as plain ints.
  bit           m_live = 1'b0;
  logic         m_req = 1'b0;
  logic         m_to = 1'b0;
  logic [1:0]   m_ch = '0;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_ovr = '0;
  logic [N-1:0] m_ev = '0;
  logic [N-1:0] m_gm = '0;
  logic [N-1:0] lvl1 = '0;
  logic [N-1:0] lvl2 = '0;
  int           m_ptr = 0;
  int           m_wait = 0;
  int           m_c = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_req  = 1'b0;
      m_to   = 1'b0;
      m_ch   = '0;
      m_pend = '0;
      m_ovr  = '0;
      lvl1   = '0;
      lvl2   = '0;
      m_ptr  = 0;
      m_wait = 0;
      m_live = 1'b1;
    end else begin
      // An event: level seen one edge ago high, two edges ago low.
      m_ev = lvl1 & ~lvl2;
      lvl2 = lvl1;
      lvl1 = tdc_stop;
      m_gm = '0;
      m_to = 1'b0;
      if (!m_req) begin
        m_c = -1;
        for (int k = 0; k < N; k++)
          if (m_c < 0 && m_pend[(m_ptr + k) % N]) m_c = (m_ptr + k) % N;
        if (m_c >= 0) begin
          m_gm[m_c] = 1'b1;
          m_ch      = 2'(m_c);
          m_ptr     = (m_c + 1) % N;
          m_req     = 1'b1;
          m_wait    = 0;
        end
      end else if (read_ack) begin
        m_req = 1'b0;
      end else begin
        m_wait++;
`ifdef TDC_READ_TIMEOUT_EN
        if (m_wait == TCYC) begin
          m_req = 1'b0;
          m_to  = 1'b1;
        end
`endif
      end
      m_ovr  = (overrun_clr ? '0 : m_ovr) | (m_ev & m_pend & ~m_gm);
      m_pend = (m_pend & ~m_gm) | m_ev;
    end
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   auto_ack = 1'b0;
  logic req_q = 1'b0;
  int   glog[$];
  int   gcyc[$];

  function automatic int gl(input int k);
    if (k < glog.size()) return glog[k];
    return -1;
  endfunction

  function automatic int gc(input int k);
    if (k < gcyc.size()) return gcyc[k];
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Every cycle: compare outputs to the model, log grants, drive auto-ack.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (m_live) begin
      n_cmp++;
      if ({read_req, read_ch, pending, overrun, timeout}
          !== {m_req, m_ch, m_pend, m_ovr, m_to}) begin
        n_bad++;
        $display("FAIL cycle %0d outputs: dut req=%b ch=%0d pend=%b ovr=%b to=%b model req=%b ch=%0d pend=%b ovr=%b to=%b",
                 cyc, read_req, read_ch, pending, overrun, timeout,
                 m_req, m_ch, m_pend, m_ovr, m_to);
      end
    end
    if (read_req && !req_q) begin
      glog.push_back(int'(read_ch));
      gcyc.push_back(cyc);
    end
    req_q = read_req;
    if (auto_ack) read_ack = read_req;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    tdc_stop    = '0;
    read_ack    = 1'b0;
    overrun_clr = 1'b0;
    auto_ack    = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!read_req && n < 20) begin
      step();
      n++;
    end
    chk(nm, int'(read_req), 1);
  endtask

  initial begin
    int base;
    int c;
    int hi;
    int tos;

    // Reset values
    do_reset();
    chk("rst_req", int'(read_req), 0);
    chk("rst_ch", int'(read_ch), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_to", int'(timeout), 0);

    // Single event on channel 2
    tdc_stop = 4'b0100;
    step();
    step();
    chk("single_pend_e1", int'(pending), 4);
    chk("single_req_e1", int'(read_req), 0);
    step();
    chk("single_req_e2", int'(read_req), 1);
    chk("single_ch", int'(read_ch), 2);
    chk("single_pend_e2", int'(pending), 0);
    step();
    step();
    read_ack = 1'b1;
    step();
    read_ack = 1'b0;
    chk("single_req_after_ack", int'(read_req), 0);
    chk("single_ovr", int'(overrun), 0);

    // Simultaneous 1011 with immediate acks, then pointer check
    do_reset();
    base     = glog.size();
    tdc_stop = 4'b1011;
    auto_ack = 1'b1;
    repeat (12) step();
    auto_ack = 1'b0;
    read_ack = 1'b0;
    chk("sim_count", glog.size() - base, 3);
    chk("sim_g0", gl(base), 0);
    chk("sim_g1", gl(base + 1), 1);
    chk("sim_g2", gl(base + 2), 3);
    chk("sim_gap01", gc(base + 1) - gc(base), 2);
    chk("sim_gap12", gc(base + 2) - gc(base + 1), 2);
    tdc_stop = '0;
    repeat (3) step();
    tdc_stop = 4'b0101;
    auto_ack = 1'b1;
    repeat (8) step();
    auto_ack = 1'b0;
    read_ack = 1'b0;
    chk("ptr_wrap_g0", gl(base + 3), 0);
    chk("ptr_wrap_g1", gl(base + 4), 2);

    // Fairness: 0 and 3 re-trigger after each of their grants
    do_reset();
    base     = glog.size();
    tdc_stop = 4'b1001;
    for (int it = 0; it < 6; it++) begin
      wait_req("fair_wait");
      c = int'(read_ch);
      read_ack    = 1'b1;
      tdc_stop[c] = 1'b0;
      step();
      read_ack    = 1'b0;
      tdc_stop[c] = 1'b1;
      step();
    end
    for (int k = 0; k < 6; k++)
      chk("fair_order", gl(base + k), (k % 2 == 0) ? 0 : 3);

    // Overrun: channel 1 rises twice while channel 0 is in service
    do_reset();
    base     = glog.size();
    tdc_stop = 4'b0001;
    repeat (3) step();
    tdc_stop[1] = 1'b1;
    repeat (2) step();
    tdc_stop[1] = 1'b0;
    repeat (2) step();
    tdc_stop[1] = 1'b1;
    repeat (3) step();
    chk("ovr_flag", int'(overrun), 2);
    chk("ovr_pend", int'(pending), 2);
    chk("ovr_hold_ch", int'(read_ch), 0);
    read_ack = 1'b1;
    step();
    read_ack = 1'b0;
    step();
    chk("ovr_next_ch", int'(read_ch), 1);
    read_ack = 1'b1;
    step();
    read_ack = 1'b0;
    repeat (4) step();
    hi = 0;
    for (int k = base; k < glog.size(); k++)
      if (glog[k] == 1) hi++;
    chk("ovr_ch1_reads", hi, 1);
    chk("ovr_sticky", int'(overrun), 2);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("ovr_clr", int'(overrun), 0);

    // Timeout behaviour
    do_reset();
    tdc_stop = 4'b0011;
    wait_req("to_wait");
    chk("to_first_ch", int'(read_ch), 0);
`ifdef TDC_READ_TIMEOUT_EN
    hi = 0;
    while (read_req && hi < 50) begin
      step();
      hi++;
    end
    chk("to_high_cycles", hi, TCYC);
    chk("to_pulse", int'(timeout), 1);
    step();
    chk("to_pulse_end", int'(timeout), 0);
    chk("to_next_req", int'(read_req), 1);
    chk("to_next_ch", int'(read_ch), 1);
`else
    hi  = 0;
    tos = 0;
    repeat (100) begin
      if (read_req) hi++;
      if (timeout) tos++;
      step();
    end
    chk("noto_high_cycles", hi, 100);
    chk("noto_pulses", tos, 0);
`endif
    read_ack = 1'b1;
    step();
    read_ack = 1'b0;

    // Reset during a request; stop stays high across reset
    do_reset();
    tdc_stop = 4'b0100;
    repeat (3) step();
    chk("rreq_before", int'(read_req), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rreq_req", int'(read_req), 0);
    chk("rreq_ch", int'(read_ch), 0);
    chk("rreq_pend", int'(pending), 0);
    chk("rreq_to", int'(timeout), 0);
    step();
    chk("rreq_r1", int'(read_req), 0);
    step();
    chk("rreq_r2_req", int'(read_req), 0);
    chk("rreq_r2_pend", int'(pending), 4);
    step();
    chk("rreq_r3_req", int'(read_req), 1);
    chk("rreq_r3_ch", int'(read_ch), 2);

    // Random traffic checked against the model every cycle
    do_reset();
    repeat (3000) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) tdc_stop[b] = ~tdc_stop[b];
      read_ack    = ($urandom_range(0, 2) == 0);
      overrun_clr = ($urandom_range(0, 19) == 0);
      reset       = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
